seq_match_scheduler: RTL and testbench

Controller that sequences a programmable serial pattern matcher, an overlapping Moore-style N-bit detector of the 1011 family. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into the match history, one bit per cycle. It also counts matches and raises a sticky threshold interrupt. Pattern and threshold are configured while idle; start/stop sequence the run.

---
 rtl/seq_match_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_seq_match_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_scheduler.sv
// Serializes valid/ready words MSB-first into an overlapping pattern matcher,
// counts matches, raises a sticky threshold irq. Optional masked compare: PATTERN_MASK_EN.
module seq_match_scheduler #(
  parameter int PAT_W  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_threshold,
`ifdef PATTERN_MASK_EN
  input  logic [PAT_W-1:0]  cfg_mask,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int SC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAT_W-1:0]    r_pattern;
  logic [CNT_W-1:0]    r_threshold;
  logic [PAT_W-2:0]    r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_word;
  logic [SC_W-1:0]     r_shcnt;
  logic                r_match_pulse;
  logic [CNT_W-1:0]    r_count;
  logic                r_irq;
  logic [PAT_W-1:0]    w_mask;
  logic                w_shifting;
  logic                w_last;
  logic                w_accept;
  logic                w_bit;
  logic [PAT_W-1:0]    w_hist_nxt;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                w_cmp;
  logic                w_match;
  logic                w_cnt_inc;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_irq_set;
  logic                w_idle;

`ifdef PATTERN_MASK_EN
  logic [PAT_W-1:0]    r_mask;
  assign w_mask = r_mask;

  // Compare mask register, loaded alongside the pattern while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '1;
    end else if (w_idle && cfg_we) begin
      r_mask <= cfg_mask;
    end
  end
`else
  assign w_mask = '1;
`endif

  assign w_idle     = (r_state == S_IDLE);
  assign w_shifting = (r_state == S_SHIFT) || (r_state == S_DRAIN);
  assign w_last     = w_shifting && (r_shcnt == SC_LAST);
  assign w_accept   = in_valid && in_ready;

  // Incoming bit joins the history; fill counts the bit being shifted in this edge.
  assign w_bit      = r_word[DATA_W-1];
  assign w_hist_nxt = {r_hist, w_bit};
  assign w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : (r_fill + FILL_W'(1));
  assign w_cmp      = (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
  assign w_match    = w_shifting && (w_fill_nxt == FILL_FULL) && w_cmp;

  assign w_cnt_inc  = w_match && (r_count != CNT_MAX);
  assign w_cnt_nxt  = r_count + CNT_W'(1);
  assign w_irq_set  = w_cnt_inc && (r_threshold != '0) && (w_cnt_nxt == r_threshold);

  assign busy        = !w_idle;
  assign match_pulse = r_match_pulse;
  assign match_count = r_count;
  assign irq         = r_irq;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; DRAIN is a SHIFT with stop already latched.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = stop ? S_DRAIN : S_SHIFT;
        end else if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_SHIFT: begin
        in_ready = w_last;
        if (w_last) begin
          if (in_valid) begin
            w_state_nxt = stop ? S_DRAIN : S_SHIFT;
          end else begin
            w_state_nxt = stop ? S_IDLE : S_WAIT;
          end
        end else if (stop) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DRAIN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration, history, match counter and sticky irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern     <= '0;
      r_threshold   <= '0;
      r_hist        <= '0;
      r_fill        <= '0;
      r_count       <= '0;
      r_irq         <= 1'b0;
      r_match_pulse <= 1'b0;
    end else begin
      if (w_idle && cfg_we) begin
        r_pattern   <= cfg_pattern;
        r_threshold <= cfg_threshold;
      end
      if (w_idle && start) begin
        r_hist  <= '0;
        r_fill  <= '0;
        r_count <= '0;
        r_irq   <= 1'b0;
      end else begin
        if (w_shifting) begin
          r_hist <= w_hist_nxt[PAT_W-2:0];
          r_fill <= w_fill_nxt;
        end
        if (w_cnt_inc) begin
          r_count <= w_cnt_nxt;
        end
        // A set in the same cycle as a clear must win.
        if (w_irq_set) begin
          r_irq <= 1'b1;
        end else if (irq_clr) begin
          r_irq <= 1'b0;
        end
      end
      r_match_pulse <= w_match;
    end
  end

  // Word shift register; an accept in the last shift cycle reloads with no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_shcnt <= '0;
    end else if (w_accept) begin
      r_word  <= in_data;
      r_shcnt <= '0;
    end else if (w_shifting) begin
      r_word  <= r_word << 1;
      r_shcnt <= r_shcnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Randomized + directed bench for seq_match_scheduler against a bit-queue reference model.
`timescale 1ns/1ps
module tb_seq_match_scheduler;
  localparam int PW = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we, start, stop, in_valid, irq_clr;
  logic [PW-1:0] cfg_pattern;
  logic [CW-1:0] cfg_threshold;
  logic [DW-1:0] in_data;
  logic          in_ready, busy, match_pulse, irq;
  logic [CW-1:0] match_count;
`ifdef PATTERN_MASK_EN
  logic [PW-1:0] cfg_mask;
`endif

  always #5 clk = ~clk;

  seq_match_scheduler #(.PAT_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_threshold(cfg_threshold),
`ifdef PATTERN_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .irq(irq), .irq_clr(irq_clr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int pulse_cyc[$];
  int a, a1, a2;

  // Reference model: run flag, pending-bit queue, recent history window.
  bit            m_run, m_pend, m_pulse, m_irq, m_acc;
  int            m_count, m_thr;
  logic [PW-1:0] m_pat, m_mask;
  bit            m_q[$];
  bit            m_hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    return m_run && !m_pend && (m_q.size() <= 1);
  endfunction

  function automatic bit m_is_match();
    if (m_hist.size() < PW) return 1'b0;
    for (int j = 0; j < PW; j++)
      if (m_mask[j] && (m_hist[m_hist.size()-1-j] != m_pat[j])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_pulse = 0; m_irq = 0; m_acc = 0;
    m_count = 0; m_thr = 0; m_pat = '0; m_mask = '1;
    m_q.delete(); m_hist.delete();
  endtask

  task automatic model_step();
    bit rdy, set_irq;
    rdy = m_ready(); set_irq = 0; m_acc = 0; m_pulse = 0;
    if (!m_run) begin
      if (cfg_we) begin
        m_pat = cfg_pattern; m_thr = int'(cfg_threshold);
`ifdef PATTERN_MASK_EN
        m_mask = cfg_mask;
`endif
      end
      if (irq_clr) m_irq = 0;
      if (start) begin
        m_run = 1; m_pend = 0; m_count = 0; m_irq = 0;
        m_hist.delete(); m_q.delete();
      end
    end else begin
      if (m_q.size() > 0) begin
        m_hist.push_back(m_q.pop_front());
        if (m_hist.size() > PW) void'(m_hist.pop_front());
        if (m_is_match()) begin
          m_pulse = 1;
          if (m_count < (2**CW) - 1) begin
            m_count++;
            if (m_thr != 0 && m_count == m_thr) set_irq = 1;
          end
        end
      end
      if (set_irq) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      m_acc = in_valid && rdy;
      if (m_acc) for (int i = DW-1; i >= 0; i--) m_q.push_back(in_data[i]);
      if (stop) m_pend = 1;
      if (m_q.size() == 0 && m_pend) begin m_run = 0; m_pend = 0; end
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_run);
      chk("in_ready", in_ready, m_ready());
      chk("match_pulse", match_pulse, m_pulse);
      chk("match_count", match_count, m_count);
      chk("irq", irq, m_irq);
      if (match_pulse) pulse_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg(input logic [PW-1:0] p, input logic [CW-1:0] t, input bit also_start);
    cfg_we = 1; cfg_pattern = p; cfg_threshold = t; start = also_start;
    tick();
    cfg_we = 0; start = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input logic [DW-1:0] w, output int acc_cyc);
    in_valid = 1; in_data = w; acc_cyc = -1;
    for (int n = 0; n < 4*DW && acc_cyc < 0; n++) begin
      tick();
      if (m_acc) acc_cyc = cyc;
    end
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %0h not accepted", w);
    end
    in_valid = 0;
  endtask

  task automatic finish_run();
    stop = 1; tick(); stop = 0;
    for (int n = 0; n < 3*DW && busy; n++) tick();
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b expected 0", busy);
    end
  endtask

  initial begin
    reset = 0; cfg_we = 0; start = 0; stop = 0; in_valid = 0; irq_clr = 0;
    cfg_pattern = '0; cfg_threshold = '0; in_data = '0;
`ifdef PATTERN_MASK_EN
    cfg_mask = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", match_count, 0);
    chk("rst_irq", irq, 0);

    // Config and start in the same cycle; single match at accept+4.
    cfg(4'b1011, 8'd0, 1'b1);
    pulse_cyc.delete();
    send(8'b1011_0000, a);
    repeat (9) tick();
    chk("t2_count", match_count, 1);
    chk("t2_irq", irq, 0);
    chk("t2_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() >= 1) chk("t2_pulse_at", pulse_cyc[0], a + 4);
    finish_run();

    // Overlap and cross-word match, back-to-back words.
    do_start();
    pulse_cyc.delete();
    send(8'b1011_0110, a1);
    send(8'b1100_0000, a2);
    repeat (9) tick();
    chk("t3_gap", a2 - a1, 8);
    chk("t3_count", match_count, 3);
    chk("t3_npulse", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("t3_p0", pulse_cyc[0], a1 + 4);
      chk("t3_p1", pulse_cyc[1], a1 + 7);
      chk("t3_p2", pulse_cyc[2], a1 + 10);
    end
    finish_run();

    // No 1011 in the stream.
    do_start();
    pulse_cyc.delete();
    send(8'b1100_1000, a);
    send(8'b0000_0011, a);
    repeat (9) tick();
    chk("t4_count", match_count, 0);
    chk("t4_npulse", pulse_cyc.size(), 0);
    finish_run();

    // Threshold 2: set beats a simultaneous clear; later clear works; no re-set.
    cfg(4'b1011, 8'd2, 1'b0);
    do_start();
    send(8'b1011_1011, a);
    repeat (7) tick();
    irq_clr = 1;
    tick();
    chk("t5_irq_set", irq, 1);
    chk("t5_count2", match_count, 2);
    tick();
    irq_clr = 0;
    chk("t5_irq_clr", irq, 0);
    send(8'b1011_0000, a);
    repeat (9) tick();
    chk("t5_count3", match_count, 3);
    chk("t5_irq_stay", irq, 0);
    finish_run();

    // Stop in the third SHIFT cycle; cfg_we while running is ignored.
    cfg(4'b1011, 8'd0, 1'b1);
    send(8'b1011_0101, a);
    repeat (2) tick();
    stop = 1; cfg_we = 1; cfg_pattern = 4'b0000;
    tick();
    stop = 0; cfg_we = 0;
    repeat (4) tick();
    chk("t6_busy_drain", busy, 1);
    chk("t6_ready_drain", in_ready, 0);
    tick();
    chk("t6_idle", busy, 0);
    chk("t6_count", match_count, 1);
    do_start();
    chk("t6_restart_cnt", match_count, 0);
    pulse_cyc.delete();
    send(8'b1000_0000, a);
    repeat (9) tick();
    chk("t6_hist_clr", pulse_cyc.size(), 0);
    finish_run();

    // Saturation with threshold at the maximum count.
    cfg(4'b0000, 8'hFF, 1'b1);
    in_valid = 1; in_data = 8'h00;
    repeat (300) tick();
    chk("sat_count", match_count, 8'hFF);
    chk("sat_irq", irq, 1);

    // Asynchronous reset mid-run with no clock edge.
    #3;
    chk_on = 0;
    reset = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_pulse", match_pulse, 0);
    chk("arst_count", match_count, 0);
    chk("arst_irq", irq, 0);
    in_valid = 0;
    @(posedge clk);
    #1 reset = 1;
    model_reset();
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_ready", in_ready, 0);
    chk_on = 1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid      = ($urandom_range(0, 9) < 7);
      in_data       = DW'($urandom);
      stop          = ($urandom_range(0, 99) < 2);
      irq_clr       = ($urandom_range(0, 99) < 5);
      cfg_we        = ($urandom_range(0, 9) == 0);
      cfg_pattern   = PW'($urandom);
      cfg_threshold = CW'($urandom_range(0, 4));
`ifdef PATTERN_MASK_EN
      cfg_mask      = PW'($urandom);
`endif
      start         = ($urandom_range(0, 9) < 3);
      tick();
    end
    in_valid = 0; irq_clr = 0; cfg_we = 0; start = 0; stop = 0;
    finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
